// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver, transmitter and their FIFOs.
package uart_pkg;
  localparam int DBIT = 8;
  localparam int SB_TICK = 16;
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_DEPTH = 2 ** FIFO_ADDR_W;
endpackage

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: pointer, occupancy and accept logic for a circular FIFO of 2**ADDR_W entries.
// A write into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  output logic              wr_en,
  output logic              rd_en,
  output logic              drop,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  always_comb begin
    empty    = count_q == '0;
    full     = count_q == {1'b1, {ADDR_W{1'b0}}};
    rd_en    = rd & ~empty;
    wr_en    = wr & (~full | rd_en);
    drop     = wr & full & ~rd_en;
    wr_ptr_d = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = (wr_en & ~rd_en) ? count_q + (ADDR_W+1)'(1) :
               (rd_en & ~wr_en) ? count_q - (ADDR_W+1)'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer behind uart_rx with sticky overrun flag.
// Define UART_RX_FIFO_DROP_CNT_EN to add a saturating dropped-byte counter output drop_cnt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT   = uart_pkg::DBIT,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_din,
  input  logic            rd,
  input  logic            overrun_clr,
  output logic [DBIT-1:0] r_data,
  output logic            empty,
  output logic            full,
  output logic [ADDR_W:0] count,
`ifdef UART_RX_FIFO_DROP_CNT_EN
  output logic [7:0]      drop_cnt,
`endif
  output logic            overrun
);
  logic              wr_en, rd_en, drop;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DBIT-1:0]   mem_q [2**ADDR_W];
  logic              overrun_q, overrun_d;

  uart_fifo_ctrl #(.ADDR_W(ADDR_W)) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .wr     (rx_done_tick),
    .rd     (rd),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .drop   (drop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .empty  (empty),
    .full   (full)
  );

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= rx_din;
  end
  assign r_data = mem_q[rd_ptr];

  // a drop in the clearing cycle keeps the flag set
  assign overrun_d = drop | (overrun_q & ~overrun_clr);
  always_ff @(posedge clk) begin
    if (reset) overrun_q <= 1'b0;
    else overrun_q <= overrun_d;
  end
  assign overrun = overrun_q;

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  always_comb begin
    drop_cnt_d = drop ? (overrun_clr ? 8'd1 : (&drop_cnt_q ? drop_cnt_q : drop_cnt_q + 8'd1)) :
                 overrun_clr ? 8'd0 : drop_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= 8'd0;
    else drop_cnt_q <= drop_cnt_d;
  end
  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (optionally with UART_RX_FIFO_DROP_CNT_EN).
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_din = 8'h00;
  logic       rd = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] r_data;
  logic       empty, full, overrun;
  logic [4:0] count;
  int         checks = 0;
  int         errors = 0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  uart_rx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_din       (rx_din),
    .rd           (rd),
    .overrun_clr  (overrun_clr),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
`ifdef UART_RX_FIFO_DROP_CNT_EN
    .drop_cnt     (drop_cnt),
`endif
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_din = b;
    tick();
    rx_done_tick = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_overrun", 32'(overrun), 0);

    push(8'hA5);
    check("one_empty", 32'(empty), 0);
    check("one_count", 32'(count), 1);
    check("one_data", 32'(r_data), 32'hA5);
    pop();
    check("one_pop_empty", 32'(empty), 1);
    check("one_pop_count", 32'(count), 0);

    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 16);
    check("fill_overrun", 32'(overrun), 0);
    push(8'hFF);
    check("drop_overrun", 32'(overrun), 1);
    check("drop_count", 32'(count), 16);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check("drop_cnt_1", 32'(drop_cnt), 1);
`endif
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(r_data), 32'(i));
      pop();
    end
    check("drain_empty", 32'(empty), 1);

    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("clr_overrun", 32'(overrun), 0);
    for (int i = 0; i < 16; i++) push(8'(i));
    rx_done_tick = 1'b1;
    rx_din = 8'h3C;
    rd = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    rd = 1'b0;
    check("wr_rd_full_count", 32'(count), 16);
    check("wr_rd_full_overrun", 32'(overrun), 0);
    check("wr_rd_full_head", 32'(r_data), 32'h01);
    for (int i = 1; i < 17; i++) begin
      check($sformatf("drain2_%0d", i), 32'(r_data), i == 16 ? 32'h3C : 32'(i));
      pop();
    end
    check("drain2_empty", 32'(empty), 1);

    pop();
    check("rd_empty_count", 32'(count), 0);
    check("rd_empty_empty", 32'(empty), 1);
    push(8'h5A);
    check("after_rd_empty_data", 32'(r_data), 32'h5A);
    check("after_rd_empty_count", 32'(count), 1);
    pop();

    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    push(8'hEE);
    check("ov_set", 32'(overrun), 1);
    rx_done_tick = 1'b1;
    overrun_clr = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    overrun_clr = 1'b0;
    check("ov_set_wins", 32'(overrun), 1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check("drop_cnt_clr_drop", 32'(drop_cnt), 1);
`endif
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ov_clr_alone", 32'(overrun), 0);
    check("ov_head_kept", 32'(r_data), 32'h10);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check("drop_cnt_zero", 32'(drop_cnt), 0);
    rx_done_tick = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    rx_done_tick = 1'b0;
    check("drop_cnt_sat", 32'(drop_cnt), 255);
    check("drop_cnt_count", 32'(count), 16);
`endif

    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    check("pre_rst_count", 32'(count), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_overrun", 32'(overrun), 0);
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h80 + i));
      check($sformatf("wrap_data_%0d", i), 32'(r_data), 32'(8'h80 + i));
      pop();
      check($sformatf("wrap_empty_%0d", i), 32'(empty), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
